// File: rtl/filtro_iir_secuencial_if.sv
// Sample/coefficient bus of the serial biquad: sample strobe in, ROM select/data,
// filtered result out.
interface filtro_iir_secuencial_if #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 25
);
  logic                     muestra_lista;
  logic signed [DATA_W-1:0] muestra_in;
  logic signed [COEF_W-1:0] cte;
  logic [3:0]               sel_cte;
  logic signed [DATA_W-1:0] dato_out;
  logic                     dato_valido;
  logic                     ocupado;

  // Environment side: ADC capture, coefficient ROM and output consumer.
  modport master (
    output muestra_lista, muestra_in, cte,
    input  sel_cte, dato_out, dato_valido, ocupado
  );

  // Filter engine side.
  modport slave (
    input  muestra_lista, muestra_in, cte,
    output sel_cte, dato_out, dato_valido, ocupado
  );
endinterface

// File: rtl/filtro_iir_secuencial.sv
// Serial-MAC biquad: one multiply-accumulate per clock over taps c0,c1,c2,c5,c6
// read from an external combinational ROM, then scale, saturate and update the
// delay lines.
module filtro_iir_secuencial #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 25,
  parameter int FRAC   = 14,
  parameter int ACC_W  = 40
) (
  input logic                    clk,
  input logic                    reset,
  filtro_iir_secuencial_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ESCALA} estado_t;

  estado_t                  estado;
  logic [2:0]               tap;
  logic signed [DATA_W-1:0] x0, x1, x2, y1, y2;
  logic signed [DATA_W-1:0] operando;
  logic signed [PROD_W-1:0] producto;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  escalado;
  logic signed [DATA_W-1:0] saturado;

  // Tap index to ROM address: feedforward taps 0..2, feedback taps at 5 and 6.
  function automatic logic [3:0] sel_de(input logic [2:0] k);
    case (k)
      3'd0:    sel_de = 4'd0;
      3'd1:    sel_de = 4'd1;
      3'd2:    sel_de = 4'd2;
      3'd3:    sel_de = 4'd5;
      3'd4:    sel_de = 4'd6;
      default: sel_de = 4'd0;
    endcase
  endfunction

  // Operand for the current tap and its full-width product with the ROM word.
  always_comb begin
    case (tap)
      3'd0:    operando = x0;
      3'd1:    operando = x1;
      3'd2:    operando = x2;
      3'd3:    operando = y1;
      3'd4:    operando = y2;
      default: operando = '0;
    endcase
    producto = $signed({{COEF_W{operando[DATA_W-1]}}, operando})
             * $signed({{DATA_W{bus.cte[COEF_W-1]}}, bus.cte});
  end

  // Fixed-point rescale (floor) and clamp to the output range.
  always_comb begin
    escalado = acc >>> FRAC;
    if (escalado > MAX_A)      saturado = MAX_D;
    else if (escalado < MIN_A) saturado = MIN_D;
    else                       saturado = escalado[DATA_W-1:0];
  end

  // Control FSM with registered outputs, datapath registers and delay lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= IDLE;
      tap             <= '0;
      acc             <= '0;
      x0              <= '0;
      x1              <= '0;
      x2              <= '0;
      y1              <= '0;
      y2              <= '0;
      bus.sel_cte     <= '0;
      bus.dato_out    <= '0;
      bus.dato_valido <= 1'b0;
      bus.ocupado     <= 1'b0;
    end else begin
      bus.dato_valido <= 1'b0;
      case (estado)
        IDLE: begin
          bus.sel_cte <= '0;
          if (bus.muestra_lista) begin
            x0          <= bus.muestra_in;
            acc         <= '0;
            tap         <= '0;
            bus.ocupado <= 1'b1;
            estado      <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PROD_W){producto[PROD_W-1]}}, producto};
          // sel_cte is loaded one cycle ahead so the ROM word matches the tap in use.
          if (tap == 3'd4) begin
            bus.sel_cte <= '0;
            estado      <= ESCALA;
          end else begin
            tap         <= tap + 3'd1;
            bus.sel_cte <= sel_de(tap + 3'd1);
          end
        end
        ESCALA: begin
          bus.dato_out    <= saturado;
          x2              <= x1;
          x1              <= x0;
          y2              <= y1;
          y1              <= saturado;
          bus.dato_valido <= 1'b1;
          bus.ocupado     <= 1'b0;
          estado          <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_iir_secuencial.sv
// Bench for the serial biquad: coefficient ROM model, directed vector table,
// hand-written timing sequences and a random run against an arithmetic model.
module tb_filtro_iir_secuencial;

  localparam int DW = 12;
  localparam int CW = 25;

  logic clk = 1'b0;
  logic reset = 1'b1;

  filtro_iir_secuencial_if #(.DATA_W(DW), .COEF_W(CW)) bus ();

  filtro_iir_secuencial #(.DATA_W(DW), .COEF_W(CW), .FRAC(14), .ACC_W(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Combinational coefficient ROM
  logic signed [CW-1:0] rom [16];
  assign bus.cte = rom[bus.sel_cte];

  int tests = 0;
  int fails = 0;

  // Reference model state: coefficients by address and the filter history
  int mc [7];
  int mx1, mx2, my1, my2;

  typedef struct {
    bit rst;
    int c0, c1, c2, c5, c6;
    int x;
    int y;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rom(input int c0, input int c1, input int c2, input int c5, input int c6);
    for (int i = 0; i < 16; i++) rom[i] = 25'h0ABCDE;
    rom[0] = CW'(c0); rom[1] = CW'(c1); rom[2] = CW'(c2);
    rom[5] = CW'(c5); rom[6] = CW'(c6);
    mc[0] = c0; mc[1] = c1; mc[2] = c2; mc[5] = c5; mc[6] = c6;
  endtask

  task automatic model_reset();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // y = floor(sum(c*operand) / 2^14), clamped to 12-bit signed
  task automatic model_step(input int x, output int y);
    longint s;
    s = longint'(mc[0]) * x + longint'(mc[1]) * mx1 + longint'(mc[2]) * mx2
      + longint'(mc[5]) * my1 + longint'(mc[6]) * my2;
    s = s >>> 14;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    y = int'(s);
    mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.muestra_lista = 1'b0;
    bus.muestra_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One sample: strobe, wait bounded for dato_valido, check latency, value, pulse width, hold
  task automatic run_sample(input int x, input int exp_y, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.muestra_lista = 1'b1;
    bus.muestra_in = DW'(x);
    @(posedge clk);
    @(negedge clk);
    bus.muestra_lista = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.dato_valido) begin
        lat = n;
        break;
      end
    end
    // valid appears on the 7th edge counting the one that took the strobe
    chk({tag, "_latency"}, lat, 6);
    chk({tag, "_y"}, int'(bus.dato_out), exp_y);
    @(posedge clk); #1;
    chk({tag, "_valid_1cyc"}, bus.dato_valido, 0);
    chk({tag, "_hold"}, int'(bus.dato_out), exp_y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int exp_sel [7] = '{0, 1, 2, 5, 6, 0, 0};

  initial begin
    int ym;
    int pulses;
    bus.muestra_lista = 1'b0;
    bus.muestra_in = '0;
    set_rom(0, 0, 0, 0, 0);
    apply_reset();

    // Reset state
    #1;
    chk("rst_dato_out", int'(bus.dato_out), 0);
    chk("rst_valid", bus.dato_valido, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_sel", bus.sel_cte, 0);

    // Directed vectors: {reset-before, c0, c1, c2, c5, c6, x, expected y}
    tbl.push_back('{1, 'h4000, 0, 0, 0, 0,  100,  100});
    tbl.push_back('{0, 'h4000, 0, 0, 0, 0,  -37,  -37});
    tbl.push_back('{0, 'h4000, 0, 0, 0, 0,    0,    0});
    tbl.push_back('{1, 0, 'h4000, 0, 0, 0,  100,    0});
    tbl.push_back('{0, 0, 'h4000, 0, 0, 0,    0,  100});
    tbl.push_back('{0, 0, 'h4000, 0, 0, 0,    0,    0});
    tbl.push_back('{1, 0, 0, 'h4000, 0, 0,  100,    0});
    tbl.push_back('{0, 0, 0, 'h4000, 0, 0,    0,    0});
    tbl.push_back('{0, 0, 0, 'h4000, 0, 0,    0,  100});
    tbl.push_back('{1, 'h4000, 0, 0, 'h2000, 0, 1024, 1024});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,    0,  512});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,    0,  256});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,    0,  128});
    tbl.push_back('{1, 'h4000, 0, 0, 'h2000, 0, -1024, -1024});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,     0,  -512});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,     0,  -256});
    tbl.push_back('{1, 'h4000, 0, 0, 'h2000, 0,    -3,    -3});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,     0,    -2});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,     0,    -1});
    tbl.push_back('{0, 'h4000, 0, 0, 'h2000, 0,     0,    -1});
    tbl.push_back('{1, 'h10000, 0, 0, 0, 0,  1000,  2047});
    tbl.push_back('{0, 'h10000, 0, 0, 0, 0, -1000, -2048});
    tbl.push_back('{0, 0, 0, 0, 'h4000, 0,      0, -2048});

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      set_rom(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c5, tbl[i].c6);
      model_step(tbl[i].x, ym);
      run_sample(tbl[i].x, tbl[i].y, $sformatf("vec%0d", i));
    end

    // sel_cte sequence; strobes during MAC and during ESCALA are ignored
    apply_reset();
    set_rom('h4000, 0, 0, 0, 0);
    pulses = 0;
    @(negedge clk);
    bus.muestra_lista = 1'b1;
    bus.muestra_in = DW'(77);
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (bus.dato_valido) begin
        pulses++;
        chk("ign_dato_out", int'(bus.dato_out), 77);
      end
      if (n < 7) chk($sformatf("sel_edge%0d", n), bus.sel_cte, exp_sel[n]);
      if (n == 0) chk("ocupado_in_mac", bus.ocupado, 1);
      if (n == 6) chk("ocupado_after", bus.ocupado, 0);
      @(negedge clk);
      bus.muestra_lista = (n == 2 || n == 5);
      bus.muestra_in = (n == 2) ? DW'(500) : DW'(900);
    end
    bus.muestra_lista = 1'b0;
    chk("ign_pulses", pulses, 1);
    // x1 must be the accepted sample, not either ignored one
    set_rom(0, 'h4000, 0, 0, 0);
    run_sample(0, 77, "ign_x1");

    // Reset during the third MAC cycle discards everything
    apply_reset();
    set_rom('h4000, 'h4000, 0, 'h2000, 0);
    run_sample(300, 300, "pre_rst");
    @(negedge clk);
    bus.muestra_lista = 1'b1;
    bus.muestra_in = DW'(200);
    @(posedge clk);
    @(negedge clk);
    bus.muestra_lista = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_dato_out", int'(bus.dato_out), 0);
    chk("mid_rst_valid", bus.dato_valido, 0);
    chk("mid_rst_ocupado", bus.ocupado, 0);
    chk("mid_rst_sel", bus.sel_cte, 0);
    @(negedge clk);
    reset = 1'b0;
    set_rom('h4000, 'h4000, 'h4000, 'h4000, 'h4000);
    run_sample(50, 50, "post_rst");

    // Random coefficients and samples against the arithmetic model
    for (int b = 0; b < 5; b++) begin
      apply_reset();
      if (b == 4)
        set_rom(int'($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000,
                int'($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000,
                int'($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000,
                int'($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000,
                int'($urandom_range(0, 32'h1FFFFFF)) - 32'sh1000000);
      else
        set_rom(int'($urandom_range(0, 65536)) - 32768,
                int'($urandom_range(0, 65536)) - 32768,
                int'($urandom_range(0, 65536)) - 32768,
                int'($urandom_range(0, 16384)) - 8192,
                int'($urandom_range(0, 16384)) - 8192);
      for (int s = 0; s < 8; s++) begin
        int x;
        x = int'($urandom_range(0, 4095)) - 2048;
        model_step(x, ym);
        run_sample(x, ym, $sformatf("rnd%0d_%0d", b, s));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
